// File: rtl/kat_adc_phase_cal.sv
// kat_adc_phase_cal: MMCM fine-phase calibration sequencer for the KAT ADC capture clock.
// Resets the MMCM and waits for lock. It then sweeps every phase position upward,
// tracking the widest error-free run, and finally steps back down to that run's centre.
module kat_adc_phase_cal #(
  parameter int NUM_STEPS    = 280,
  parameter int PHASE_W      = 9,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int PSDONE_TO    = 255,
  parameter int SETTLE       = 32,
  parameter int DWELL        = 1024,
  parameter int MIN_EYE      = 8
) (
  input  logic               ctrl_clk_in,
  input  logic               ctrl_reset,
  input  logic               cal_start,
  input  logic               cal_abort,
  input  logic               mmcm_locked,
  input  logic               mmcm_psdone,
  input  logic               data_valid,
  input  logic               data_ok,
  output logic               mmcm_reset,
  output logic               mmcm_psen,
  output logic               mmcm_psincdec,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_fail,
  output logic [PHASE_W-1:0] cal_phase,
  output logic [PHASE_W-1:0] cal_eye_start,
  output logic [PHASE_W-1:0] cal_eye_width
);

  // One shared counter serves every timed state, so it is sized for the longest wait.
  localparam int M1      = (LOCK_TIMEOUT > DWELL) ? LOCK_TIMEOUT : DWELL;
  localparam int M2      = (PSDONE_TO > SETTLE) ? PSDONE_TO : SETTLE;
  localparam int M3      = (M1 > M2) ? M1 : M2;
  localparam int CNT_MAX = (M3 > RST_CYCLES) ? M3 : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   PS_LAST     = CNT_W'(PSDONE_TO - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL - 1);
  localparam logic [PHASE_W-1:0] PH_LAST     = PHASE_W'(NUM_STEPS - 1);
  localparam logic [PHASE_W-1:0] MIN_W       = PHASE_W'(MIN_EYE);

  typedef enum logic [3:0] {
    S_IDLE, S_MRST, S_WLOCK, S_SETTLE, S_DWELL, S_EVAL,
    S_STEP, S_WPS, S_SEEK, S_SWAIT, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] run_len_q, run_len_d;
  logic [PHASE_W-1:0] run_start_q, run_start_d;
  logic [PHASE_W-1:0] eye_start_q, eye_start_d;
  logic [PHASE_W-1:0] eye_w_q, eye_w_d;

  logic [PHASE_W-1:0] target;
  logic [PHASE_W-1:0] run_len_new, run_start_new;
  logic               lock_watch, lock_lost, seek_move;

  // Window centre (floored) and the run update that EVAL would commit this cycle.
  always_comb begin
    target        = eye_start_q + (eye_w_q >> 1);
    run_len_new   = err_q ? '0 : run_len_q + 1'b1;
    run_start_new = (!err_q && run_len_q == '0) ? phase_q : run_start_q;
    lock_watch    = (state_q == S_SETTLE) || (state_q == S_DWELL) || (state_q == S_EVAL) ||
                    (state_q == S_STEP)   || (state_q == S_WPS)   || (state_q == S_SEEK) ||
                    (state_q == S_SWAIT);
    lock_lost     = lock_watch && !mmcm_locked;
    seek_move     = (state_q == S_SEEK) && (phase_q != target);
  end

  // Next-state and datapath update; abort beats lock loss, which beats normal sequencing.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    phase_d     = phase_q;
    run_len_d   = run_len_q;
    run_start_d = run_start_q;
    eye_start_d = eye_start_q;
    eye_w_d     = eye_w_q;
    if (cal_abort) begin
      state_d     = S_IDLE;
      err_d       = 1'b0;
      phase_d     = '0;
      run_len_d   = '0;
      run_start_d = '0;
      eye_start_d = '0;
      eye_w_d     = '0;
    end else if (lock_lost) begin
      state_d = S_FAIL;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (cal_start) begin
            state_d     = S_MRST;
            err_d       = 1'b0;
            phase_d     = '0;
            run_len_d   = '0;
            run_start_d = '0;
            eye_start_d = '0;
            eye_w_d     = '0;
          end
        end
        S_MRST: begin
          phase_d = '0;
          if (cnt_q == RST_LAST) state_d = S_WLOCK;
        end
        S_WLOCK: begin
          if (mmcm_locked)             state_d = S_SETTLE;
          else if (cnt_q == LOCK_LAST) state_d = S_FAIL;
        end
        S_SETTLE: begin
          err_d = 1'b0;
          if (cnt_q == SETTLE_LAST) state_d = S_DWELL;
        end
        S_DWELL: begin
          if (data_valid) begin
            if (!data_ok) err_d = 1'b1;
            if (cnt_q == DWELL_LAST) state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          run_len_d   = run_len_new;
          run_start_d = run_start_new;
          // Strictly wider only: an equal later window never displaces the first one.
          if (run_len_new > eye_w_q) begin
            eye_start_d = run_start_new;
            eye_w_d     = run_len_new;
          end
          if (phase_q < PH_LAST)   state_d = S_STEP;
          else if (eye_w_d < MIN_W) state_d = S_FAIL;
          else                      state_d = S_SEEK;
        end
        S_STEP: state_d = S_WPS;
        S_WPS: begin
          if (mmcm_psdone) begin
            phase_d = phase_q + 1'b1;
            state_d = S_SETTLE;
          end else if (cnt_q == PS_LAST) begin
            state_d = S_FAIL;
          end
        end
        S_SEEK: state_d = seek_move ? S_SWAIT : S_DONE;
        S_SWAIT: begin
          if (mmcm_psdone) begin
            phase_d = phase_q - 1'b1;
            state_d = S_SEEK;
          end else if (cnt_q == PS_LAST) begin
            state_d = S_FAIL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter restarts on every state change; DWELL counts only valid words; idle states hold zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_DWELL && !data_valid)
      cnt_d = cnt_q;
    else if (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL)
      cnt_d = '0;
  end

  // Outputs decode from state; abort and lock loss drop the MMCM strobes in the same cycle.
  always_comb begin
    mmcm_reset    = (state_q == S_MRST) && !cal_abort;
    mmcm_psen     = !cal_abort && !lock_lost && ((state_q == S_STEP) || seek_move);
    mmcm_psincdec = mmcm_psen && (state_q == S_STEP);
    cal_busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    cal_done      = (state_q == S_DONE);
    cal_fail      = (state_q == S_FAIL);
    cal_phase     = phase_q;
    cal_eye_start = eye_start_q;
    cal_eye_width = eye_w_q;
  end

  // State and datapath registers.
  always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      phase_q     <= '0;
      run_len_q   <= '0;
      run_start_q <= '0;
      eye_start_q <= '0;
      eye_w_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      phase_q     <= phase_d;
      run_len_q   <= run_len_d;
      run_start_q <= run_start_d;
      eye_start_q <= eye_start_d;
      eye_w_q     <= eye_w_d;
    end
  end

endmodule
